bram_port_arb: RTL and testbench
================================

# bram_port_arb

Two-client arbiter and burst sequencer for a single-port accelerator BRAM (32-bit words, byte addressing, 1-cycle read latency). Clients issue single-word writes or multi-word burst reads by word index. The block grants one client at a time round-robin, drives the BRAM port, and steers returned read data back with a valid strobe and an end-of-command pulse. It sits between the feature-map/weight loaders and the on-chip buffer BRAM.

## Interface
Parameters:
- LEN_W, 9, width of burst length field (max 2^LEN_W−1 words)
- WADDR_W, 30, width of word index; byte address = word index × 4

Ports (i = 0, 1, one set per client):
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous, active-high reset
- ci_req  in  1  command request; held with command fields until ci_gnt
- ci_we  in  1  1 = single-word write, 0 = burst read
- ci_base  in  WADDR_W  starting word index
- ci_len  in  LEN_W  read burst length in words; 0 treated as 1; ignored for writes
- ci_wdata  in  32  write data
- ci_gnt  out  1  one-cycle pulse: command accepted (fields captured at the preceding edge)
- ci_rvalid  out  1  read data valid on ci_rdata
- ci_rdata  out  32  read data (both clients see bram_dout; only own rvalid qualifies)
- ci_done  out  1  one-cycle pulse: command complete
- bram_addr  out  32  byte address = {word, 2'b00}
- bram_en  out  1  port enable
- bram_wen  out  4  4'b1111 on write, 4'b0000 otherwise
- bram_din  out  32  write data
- bram_dout  in  32  read data, valid the cycle after bram_en with wen = 0

## Operation
- States: IDLE, RD, RD_LAST, WR.
- Arbitration evaluated in IDLE and RD_LAST. One requester → grant it. Both → grant the client not granted last (pointer = last owner; reset value selects client 0 first).
- At arbitration edge: capture owner, we, base, len (0→1), wdata; next state WR if we else RD; ci_gnt of owner high in the following cycle.
- RD: beat counter k = 0..len−1, one per cycle; bram_en = 1, bram_wen = 0, bram_addr = ((base + k) mod 2^WADDR_W) × 4. Word index wraps silently. On k = len−1 go to RD_LAST.
- RD_LAST: bram_en = 0; owner's ci_rvalid and ci_done high (last beat). Arbitration runs here.
- Owner's ci_rvalid is high in every cycle after an RD beat (registered copy of the RD-beat enable).
- WR: one cycle; bram_en = 1, bram_wen = 4'b1111, bram_din = captured wdata, bram_addr = base × 4; ci_gnt and ci_done of owner both high. Next state IDLE.
- Non-owner outputs (gnt, rvalid, done) stay 0. Requests arriving during a command wait; no preemption.
- Reset: state IDLE; all ci_gnt, ci_rvalid, ci_done, bram_en = 0; bram_wen = 0; bram_addr, bram_din = 0; pointer = client 0 first. Reset mid-burst aborts: no further rvalid or done for the aborted command.

## Timing
- Read, len L, req visible in cycle 0 (IDLE): gnt + first bram_en in cycle 1; rvalid cycles 2..L+1; done in cycle L+1. A pending request is granted earliest in cycle L+2 (bram idle exactly one cycle between bursts).
- Write, req in cycle 0: gnt + done + BRAM write in cycle 1; IDLE in cycle 2; next grant earliest cycle 3.
- Simultaneous req in IDLE after reset: client 0 first, client 1 next.
- Read of a word written by the previous command returns the new value (write completes before any later read beat).

## Test plan
- Memory model mem[i] = 0x100 + i. c0 read base 4, len 3 → c0_gnt cycle 1; bram_addr 0x10, 0x14, 0x18 in cycles 1–3; c0_rvalid cycles 2–4 with 0x104, 0x105, 0x106; c0_done cycle 4 only.
- c1 write base 7, wdata 0xDEADBEEF, then c1 read base 7 len 1 → bram_wen 4'b1111 at addr 0x1C in grant cycle; read returns 0xDEADBEEF with done.
- Both request reads (len 2) from reset, both held → c0 served first, c1 granted in the cycle after c0_done; c1_rvalid never overlaps c0_rvalid; then both again → c1 served before c0.
- c0 read len 0, base 0 → treated as 1: one bram_en, one rvalid (0x100) coinciding with done.
- Read base 2^30−1, len 2 → bram_addr 0xFFFFFFFC then 0x00000000.
- rst asserted during beat 2 of a len-5 read → next cycle all outputs 0, no done; after release, c1 and c0 requesting together → c0 granted.

Source files
------------

// File: rtl/bram_port_arb.sv
// Two-client round-robin arbiter and burst sequencer in front of a single-port 32-bit BRAM.
// Latency: grant and first BRAM access 1 cycle after request; read data 1 cycle after each beat.
// Backpressure: clients hold req until gnt; losers wait for IDLE/RD_LAST, no preemption.
module bram_port_arb #(
   parameter int LEN_W   = 9,
   parameter int WADDR_W = 30
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               c0_req,
   input  logic               c0_we,
   input  logic [WADDR_W-1:0] c0_base,
   input  logic [LEN_W-1:0]   c0_len,
   input  logic [31:0]        c0_wdata,
   output logic               c0_gnt,
   output logic               c0_rvalid,
   output logic [31:0]        c0_rdata,
   output logic               c0_done,
   input  logic               c1_req,
   input  logic               c1_we,
   input  logic [WADDR_W-1:0] c1_base,
   input  logic [LEN_W-1:0]   c1_len,
   input  logic [31:0]        c1_wdata,
   output logic               c1_gnt,
   output logic               c1_rvalid,
   output logic [31:0]        c1_rdata,
   output logic               c1_done,
   output logic [31:0]        bram_addr,
   output logic               bram_en,
   output logic [3:0]         bram_wen,
   output logic [31:0]        bram_din,
   input  logic [31:0]        bram_dout
);

   typedef enum logic [1:0] {IDLE, RD, RD_LAST, WR} state_t;

   state_t             state_q, state_d;
   logic               owner_q, owner_d;   // 0 = client 0
   logic               last_q, last_d;     // last owner; resets to 1 so client 0 wins the first tie
   logic [WADDR_W-1:0] word_q, word_d;     // current word index
   logic [LEN_W-1:0]   rem_q, rem_d;       // beats left including the current one
   logic [31:0]        wdata_q, wdata_d;
   logic [1:0]         gnt_q, gnt_d;
   logic [1:0]         rvalid_q, rvalid_d;

   logic               pick;
   logic               sel_we;
   logic [WADDR_W-1:0] sel_base;
   logic [LEN_W-1:0]   sel_len;
   logic [31:0]        sel_wdata;
   logic [1:0]         done_vec;

   // Round-robin choice and the winner's command fields
   always_comb begin
      if (c0_req && c1_req) begin
         pick = ~last_q;
      end else begin
         pick = c1_req;
      end
      sel_we    = pick ? c1_we    : c0_we;
      sel_base  = pick ? c1_base  : c0_base;
      sel_len   = pick ? c1_len   : c0_len;
      sel_wdata = pick ? c1_wdata : c0_wdata;
   end

   // Next-state: burst stepping, then arbitration in IDLE and RD_LAST
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      word_d   = word_q;
      rem_d    = rem_q;
      wdata_d  = wdata_q;
      gnt_d    = 2'b00;
      rvalid_d = 2'b00;
      // read data returns one cycle after every RD beat
      if (state_q == RD) begin
         rvalid_d[owner_q] = 1'b1;
      end
      case (state_q)
         RD: begin
            if (rem_q == LEN_W'(1)) begin
               state_d = RD_LAST;
            end else begin
               rem_d  = rem_q - LEN_W'(1);
               word_d = word_q + WADDR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if ((state_q == IDLE || state_q == RD_LAST) && (c0_req || c1_req)) begin
         owner_d      = pick;
         last_d       = pick;
         gnt_d[pick]  = 1'b1;
         word_d       = sel_base;
         rem_d        = (sel_len == '0) ? LEN_W'(1) : sel_len;
         wdata_d      = sel_wdata;
         state_d      = sel_we ? WR : RD;
      end
   end

   // State registers with synchronous reset; reset aborts any burst in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         word_q   <= '0;
         rem_q    <= '0;
         wdata_q  <= '0;
         gnt_q    <= 2'b00;
         rvalid_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         word_q   <= word_d;
         rem_q    <= rem_d;
         wdata_q  <= wdata_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
      end
   end

   // BRAM port drive and completion strobes decoded from state
   always_comb begin
      bram_en   = 1'b0;
      bram_wen  = 4'b0000;
      bram_addr = '0;
      bram_din  = '0;
      done_vec  = 2'b00;
      case (state_q)
         RD: begin
            bram_en   = 1'b1;
            bram_addr = 32'({word_q, 2'b00});
         end
         WR: begin
            bram_en           = 1'b1;
            bram_wen          = 4'b1111;
            bram_addr         = 32'({word_q, 2'b00});
            bram_din          = wdata_q;
            done_vec[owner_q] = 1'b1;
         end
         RD_LAST: done_vec[owner_q] = 1'b1;
         default: ;
      endcase
   end

   assign c0_gnt    = gnt_q[0];
   assign c1_gnt    = gnt_q[1];
   assign c0_rvalid = rvalid_q[0];
   assign c1_rvalid = rvalid_q[1];
   assign c0_done   = done_vec[0];
   assign c1_done   = done_vec[1];
   assign c0_rdata  = bram_dout;
   assign c1_rdata  = bram_dout;

endmodule

// File: tb/tb_bram_port_arb.sv
// Bench for bram_port_arb: directed cycle table, hand sequences for arbitration and reset abort,
// then randomized traffic against a transaction-level schedule model.
// Each cycle's outputs are sampled just after the falling edge, where the inputs are also driven.
module tb_bram_port_arb;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [29:0] base;
      logic [8:0]  len;
      logic [31:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic [1:0]  gnt;   // bit 0 = client 0
      logic [1:0]  rv;
      logic [1:0]  done;
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      cmd_t c0;
      cmd_t c1;
      exp_t e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        c0_req, c0_we, c1_req, c1_we;
   logic [29:0] c0_base, c1_base;
   logic [8:0]  c0_len, c1_len;
   logic [31:0] c0_wdata, c1_wdata;
   logic        c0_gnt, c0_rvalid, c0_done, c1_gnt, c1_rvalid, c1_done;
   logic [31:0] c0_rdata, c1_rdata;
   logic [31:0] bram_addr, bram_din, bram_dout;
   logic        bram_en;
   logic [3:0]  bram_wen;

   int errors = 0;
   int checks = 0;

   localparam int NRAND = 2000;
   localparam int RING  = 1024;

   always #5 clk = ~clk;

   bram_port_arb #(.LEN_W(9), .WADDR_W(30)) dut (
      .clk(clk), .rst(rst),
      .c0_req(c0_req), .c0_we(c0_we), .c0_base(c0_base), .c0_len(c0_len), .c0_wdata(c0_wdata),
      .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata), .c0_done(c0_done),
      .c1_req(c1_req), .c1_we(c1_we), .c1_base(c1_base), .c1_len(c1_len), .c1_wdata(c1_wdata),
      .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata), .c1_done(c1_done),
      .bram_addr(bram_addr), .bram_en(bram_en), .bram_wen(bram_wen), .bram_din(bram_din),
      .bram_dout(bram_dout)
   );

   function automatic logic [31:0] init_word(input logic [29:0] a);
      return 32'h100 + {2'b00, a};
   endfunction

   // BRAM behaviour: unwritten word i holds 0x100 + i, 1-cycle read latency
   logic [31:0] hw_mem [logic [29:0]];
   initial begin
      bram_dout = '0;
      forever begin
         @(posedge clk);
         if (bram_en === 1'b1) begin
            if (bram_wen == 4'hF) begin
               hw_mem[bram_addr[31:2]] = bram_din;
            end else begin
               bram_dout = hw_mem.exists(bram_addr[31:2]) ? hw_mem[bram_addr[31:2]]
                                                          : init_word(bram_addr[31:2]);
            end
         end
      end
   end

   // Reference memory contents as seen by the schedule model
   logic [31:0] mdl_mem [logic [29:0]];
   function automatic logic [31:0] mdl_rd(input logic [29:0] a);
      return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
   endfunction

   function automatic cmd_t rd(input logic [29:0] b, input logic [8:0] l);
      cmd_t c;
      c = '0; c.req = 1'b1; c.base = b; c.len = l;
      return c;
   endfunction

   function automatic cmd_t wr(input logic [29:0] b, input logic [31:0] d);
      cmd_t c;
      c = '0; c.req = 1'b1; c.we = 1'b1; c.base = b; c.wdata = d;
      return c;
   endfunction

   function automatic exp_t ex(input logic [1:0] g, input logic [1:0] v, input logic [1:0] d,
                               input logic en, input logic [3:0] wen,
                               input logic [31:0] addr, input logic [31:0] din,
                               input logic [31:0] rdata);
      exp_t e;
      e.gnt = g; e.rv = v; e.done = d; e.en = en; e.wen = wen;
      e.addr = addr; e.din = din; e.rdata = rdata;
      return e;
   endfunction

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c = '0;
      c.req   = 1'b1;
      c.we    = ($urandom_range(0, 3) == 0);
      c.base  = ($urandom_range(0, 5) == 0) ? 30'h3FFF_FFFF - 30'($urandom_range(0, 3))
                                            : 30'($urandom_range(0, 15));
      c.len   = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 6));
      c.wdata = $urandom;
      return c;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input cmd_t a, input cmd_t b);
      c0_req = a.req; c0_we = a.we; c0_base = a.base; c0_len = a.len; c0_wdata = a.wdata;
      c1_req = b.req; c1_we = b.we; c1_base = b.base; c1_len = b.len; c1_wdata = b.wdata;
   endtask

   task automatic check_cycle(input string tag, input exp_t e);
      check({tag, " ctl{gnt,rv,done,en,wen}"},
            64'({c1_gnt, c0_gnt, c1_rvalid, c0_rvalid, c1_done, c0_done, bram_en, bram_wen}),
            64'({e.gnt, e.rv, e.done, e.en, e.wen}));
      if (e.en)        check({tag, " bram_addr"}, 64'(bram_addr), 64'(e.addr));
      if (e.wen != '0) check({tag, " bram_din"}, 64'(bram_din), 64'(e.din));
      if (e.rv[0])     check({tag, " c0_rdata"}, 64'(c0_rdata), 64'(e.rdata));
      if (e.rv[1])     check({tag, " c1_rdata"}, 64'(c1_rdata), 64'(e.rdata));
   endtask

   // Leaves the bench at a falling edge with reset released: that cycle is cycle 0
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive('0, '0);
      repeat (2) @(negedge clk);
      #1;
      check("reset ctl", 64'({c1_gnt, c0_gnt, c1_rvalid, c0_rvalid, c1_done, c0_done, bram_en, bram_wen}), 64'd0);
      check("reset addr/din", {bram_addr, bram_din}, 64'd0);
      rst = 1'b0;
   endtask

   vec_t  tbl[$];
   exp_t  ring [RING];
   exp_t  e0;
   cmd_t  noc;
   cmd_t  cur [2];
   int    gap [2];
   int    gcnt [2];
   int    gcy [2][4];
   int    dfirst [2];
   int    ovl;
   int    arb_at;
   int    last;

   initial begin
      rst = 1'b1;
      drive('0, '0);
      e0  = '0;
      noc = '0;

      // ---- directed cycle table (index = cycle after reset) ----
      tbl.push_back('{rd(30'd4, 9'd3), noc, e0});
      tbl.push_back('{noc, noc, ex(2'b01, 2'b00, 2'b00, 1'b1, 4'h0, 32'h10, 0, 0)});
      tbl.push_back('{noc, noc, ex(2'b00, 2'b01, 2'b00, 1'b1, 4'h0, 32'h14, 0, 32'h104)});
      tbl.push_back('{noc, noc, ex(2'b00, 2'b01, 2'b00, 1'b1, 4'h0, 32'h18, 0, 32'h105)});
      tbl.push_back('{noc, noc, ex(2'b00, 2'b01, 2'b01, 1'b0, 4'h0, 0, 0, 32'h106)});
      tbl.push_back('{noc, noc, e0});
      tbl.push_back('{noc, wr(30'd7, 32'hDEADBEEF), e0});
      tbl.push_back('{noc, noc, ex(2'b10, 2'b00, 2'b10, 1'b1, 4'hF, 32'h1C, 32'hDEADBEEF, 0)});
      tbl.push_back('{noc, rd(30'd7, 9'd1), e0});
      tbl.push_back('{noc, noc, ex(2'b10, 2'b00, 2'b00, 1'b1, 4'h0, 32'h1C, 0, 0)});
      tbl.push_back('{noc, noc, ex(2'b00, 2'b10, 2'b10, 1'b0, 4'h0, 0, 0, 32'hDEADBEEF)});
      tbl.push_back('{rd(30'd0, 9'd0), noc, e0});
      tbl.push_back('{noc, noc, ex(2'b01, 2'b00, 2'b00, 1'b1, 4'h0, 32'h0, 0, 0)});
      tbl.push_back('{noc, noc, ex(2'b00, 2'b01, 2'b01, 1'b0, 4'h0, 0, 0, 32'h100)});
      tbl.push_back('{rd(30'h3FFF_FFFF, 9'd2), noc, e0});
      tbl.push_back('{noc, noc, ex(2'b01, 2'b00, 2'b00, 1'b1, 4'h0, 32'hFFFF_FFFC, 0, 0)});
      tbl.push_back('{noc, noc, ex(2'b00, 2'b01, 2'b00, 1'b1, 4'h0, 32'h0, 0, 32'h4000_00FF)});
      tbl.push_back('{noc, noc, ex(2'b00, 2'b01, 2'b01, 1'b0, 4'h0, 0, 0, 32'h100)});
      tbl.push_back('{noc, noc, e0});

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].c0, tbl[i].c1);
         #1;
         check_cycle($sformatf("vec%0d", i), tbl[i].e);
         @(negedge clk);
      end
      // the directed write above also landed in the BRAM
      mdl_mem[30'd7] = 32'hDEADBEEF;

      // ---- arbitration: tie from reset, tie at RD_LAST, tie from IDLE ----
      do_reset();
      for (int i = 0; i < 2; i++) begin
         gcnt[i] = 0; dfirst[i] = -1;
         for (int j = 0; j < 4; j++) gcy[i][j] = -1;
      end
      ovl = 0;
      drive(rd(30'h20, 9'd2), rd(30'h40, 9'd2));
      for (int t = 0; t < 20; t++) begin
         #1;
         if (c0_gnt) begin if (gcnt[0] < 4) gcy[0][gcnt[0]] = t; gcnt[0]++; c0_req = 1'b0; end
         if (c1_gnt) begin if (gcnt[1] < 4) gcy[1][gcnt[1]] = t; gcnt[1]++; c1_req = 1'b0; end
         if (c0_done && dfirst[0] < 0) dfirst[0] = t;
         if (c1_done && dfirst[1] < 0) dfirst[1] = t;
         if (c0_rvalid && c1_rvalid) ovl++;
         if (t == 2) begin
            c0_req = 1'b1; c0_we = 1'b0; c0_base = 30'h60; c0_len = 9'd2;
         end
         if (t == 11) drive(rd(30'h70, 9'd2), rd(30'h80, 9'd2));
         @(negedge clk);
      end
      check("arb c0 first grant cycle",  64'(gcy[0][0]), 64'd1);
      check("arb c0 first done cycle",   64'(dfirst[0]), 64'd3);
      check("arb c1 first grant cycle",  64'(gcy[1][0]), 64'd4);
      check("arb c1 first done cycle",   64'(dfirst[1]), 64'd6);
      check("arb c0 second grant cycle", 64'(gcy[0][1]), 64'd7);
      check("arb c1 idle-tie grant",     64'(gcy[1][1]), 64'd12);
      check("arb c0 after idle-tie",     64'(gcy[0][2]), 64'd15);
      check("arb rvalid overlap count",  64'(ovl), 64'd0);

      // ---- reset during beat 2 of a len-5 read ----
      do_reset();
      drive(rd(30'h50, 9'd5), noc);
      #1;
      @(negedge clk);
      #1;
      check_cycle("abort c1", ex(2'b01, 2'b00, 2'b00, 1'b1, 4'h0, 32'h140, 0, 0));
      c0_req = 1'b0;
      @(negedge clk);
      #1;
      check_cycle("abort c2", ex(2'b00, 2'b01, 2'b00, 1'b1, 4'h0, 32'h144, 0, 32'h150));
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_cycle("abort c3", e0);
      check("abort c3 addr/din", {bram_addr, bram_din}, 64'd0);
      rst = 1'b0;
      for (int t = 4; t < 7; t++) begin
         @(negedge clk);
         #1;
         check_cycle($sformatf("abort c%0d", t), e0);
      end
      drive(rd(30'h5, 9'd1), rd(30'h9, 9'd1));
      @(negedge clk);
      #1;
      check_cycle("abort regrant", ex(2'b01, 2'b00, 2'b00, 1'b1, 4'h0, 32'h14, 0, 0));

      // ---- randomized traffic against the schedule model ----
      do_reset();
      for (int i = 0; i < RING; i++) ring[i] = '0;
      for (int i = 0; i < 2; i++) begin cur[i] = '0; gap[i] = 0; end
      arb_at = 0;
      last   = 1;
      for (int t = 0; t < NRAND + 1200; t++) begin
         exp_t e;
         e = ring[t % RING];
         ring[t % RING] = '0;
         #1;
         check_cycle($sformatf("rnd%0d", t), e);
         for (int i = 0; i < 2; i++) begin
            if (e.gnt[i]) begin
               cur[i].req = 1'b0;
               gap[i] = $urandom_range(0, 3);
            end else if (!cur[i].req) begin
               if (gap[i] > 0) gap[i]--;
               else if (t < NRAND && $urandom_range(0, 1) == 1) cur[i] = rand_cmd();
            end
         end
         drive(cur[0], cur[1]);
         if (t >= arb_at && (cur[0].req || cur[1].req)) begin
            int   w, g, len;
            cmd_t c;
            w = (cur[0].req && cur[1].req) ? 1 - last : (cur[1].req ? 1 : 0);
            last = w;
            c = cur[w];
            g = t + 1;
            ring[g % RING].gnt[w] = 1'b1;
            if (c.we) begin
               ring[g % RING].done[w] = 1'b1;
               ring[g % RING].en      = 1'b1;
               ring[g % RING].wen     = 4'hF;
               ring[g % RING].addr    = {c.base, 2'b00};
               ring[g % RING].din     = c.wdata;
               mdl_mem[c.base] = c.wdata;
               arb_at = t + 2;
            end else begin
               len = (c.len == '0) ? 1 : int'(c.len);
               for (int k = 0; k < len; k++) begin
                  logic [29:0] a;
                  a = c.base + 30'(k);
                  ring[(g + k) % RING].en        = 1'b1;
                  ring[(g + k) % RING].addr      = {a, 2'b00};
                  ring[(g + k + 1) % RING].rv[w] = 1'b1;
                  ring[(g + k + 1) % RING].rdata = mdl_rd(a);
               end
               ring[(g + len) % RING].done[w] = 1'b1;
               arb_at = g + len;
            end
         end
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
